flash_page_loader: RTL and testbench
====================================

FLASH_PAGE_LOADER -- requirements
Module: flash_page_loader

Interface
REQ-001 SHALL have parameter PAGE_WORDS, default 512, meaning 32-bit words per cached flash page.
REQ-002 SHALL have parameter FLASH_ADDRESS_BITS, default 24, meaning SPI flash byte-address width.
REQ-003 SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-004 SHALL have ports, clock and reset first:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  loader enable (flash config bit 0).
- loadRequest  input  1  one-cycle pulse that starts a page load.
- pageAddress  input  13  page number, flash byte address = pageAddress * 2048.
- busy  output  1  load in progress.
- pageValid  output  1  SRAM holds a complete page.
- loadedPage  output  13  page number of last completed load.
- flash_csb  output  1  SPI chip select, active low.
- flash_clk  output  1  SPI clock, mode 0.
- flash_io0  output  1  SPI MOSI.
- flash_io1  input  1  SPI MISO.
- sramWriteEnable  output  1  one-cycle write strobe to page cache SRAM.
- sramAddress  output  9  word index within page.
- sramData  output  32  assembled word.

Function
REQ-005 SHALL implement states IDLE, COMMAND, ADDRESS, DATA, DONE.
REQ-006 IDLE: on loadRequest=1 with enable=1, SHALL latch pageAddress, set busy=1, drive flash_csb=0 the next cycle and enter COMMAND.
REQ-007 loadRequest in any state other than IDLE SHALL be ignored; loadRequest with enable=0 SHALL be ignored.
REQ-008 Each SPI bit SHALL take 2 clk cycles: flash_clk low phase then high phase; flash_io0 changes only while flash_clk is low; flash_io1 is sampled on the clk edge that drives flash_clk high.
REQ-009 COMMAND SHALL shift 8'h03 MSB first (8 bits), then enter ADDRESS.
REQ-010 ADDRESS SHALL shift {latchedPage, 11'b0} (24 bits) MSB first, then enter DATA.
REQ-011 DATA SHALL receive bytes MSB first; byte n of each word SHALL land in sramData[8n+7:8n] (little-endian).
REQ-012 After each 32nd data bit, SHALL pulse sramWriteEnable for exactly 1 cycle with sramAddress = word index (0..PAGE_WORDS-1) and sramData = assembled word.
REQ-013 After word PAGE_WORDS-1 is written, SHALL enter DONE: flash_csb=1, flash_clk=0, loadedPage=latchedPage, pageValid=1; return to IDLE with busy=0 the next cycle.
REQ-014 A full load SHALL take (8+24+32*PAGE_WORDS)*2 clk cycles from first flash_clk low phase to DONE (32832 at default).
REQ-015 pageValid SHALL clear on the cycle loadRequest is accepted and stay 0 until DONE.
REQ-016 enable dropping to 0 in any non-IDLE state SHALL abort: next cycle flash_csb=1, flash_clk=0, busy=0, pageValid=0, no further SRAM writes, state IDLE.
REQ-017 Simultaneous enable falling and loadRequest SHALL abort or ignore (enable wins).
REQ-018 Word index SHALL not wrap: it stops at PAGE_WORDS-1; the bit counter SHALL reset on each state entry.

Reset
REQ-019 rst_n=0 SHALL immediately force: state IDLE, busy=0, pageValid=0, loadedPage=0, flash_csb=1, flash_clk=0, flash_io0=0, sramWriteEnable=0, sramAddress=0, sramData=0.
REQ-020 Reset asserted mid-load SHALL abort the transfer with no further SRAM write after deassertion.

Structure
REQ-021 A shared package flash_pkg SHALL hold FLASH_READ_CMD (8'h03), PAGE_WORDS default, the state typedef and the page-address width.
REQ-022 The bit-level shift/clock generator SHALL be one sub-module, flash_spi_shifter (load byte/word, bit count, done strobe); the FSM and SRAM write logic stay in the top.

Verification
REQ-023 Page 0 load from spiflash model with word0=32'h0000_0513: exactly 512 sramWriteEnable pulses, word 0 data 32'h0000_0513, pageValid=1 and loadedPage=0 after 32832 cycles.
REQ-024 pageAddress=13'd3: MOSI bit stream is 8'h03 then 24'h001800; SRAM word 0 equals flash bytes 0x1800..0x1803 little-endian.
REQ-025 loadRequest pulses at cycles 100 and 5000 of one load: second ignored, single 512-word load, busy high throughout.
REQ-026 enable=0 at word 200: flash_csb=1 next cycle, pageValid=0, no write with sramAddress>=200 afterward.
REQ-027 rst_n pulse low for 3 cycles mid-DATA: outputs at reset values immediately, no SRAM write after release until a new loadRequest.
REQ-028 flash_clk checker: high/low phases exactly 1 clk each while flash_csb=0, flash_clk=0 whenever flash_csb=1.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared constants, state encoding and helpers for the SPI flash page loader.
package flash_pkg;

  localparam logic [7:0]  FLASH_READ_CMD     = 8'h03;
  localparam int unsigned PAGE_WORDS_DEFAULT = 512;
  localparam int unsigned PAGE_ADDR_BITS     = 13;
  // 2048-byte pages: flash byte address = page number << 11
  localparam int unsigned PAGE_OFFSET_BITS   = 11;
  localparam int unsigned WORD_IDX_BITS      = 9;

  typedef enum logic [2:0] {
    StIdle,
    StCommand,
    StAddress,
    StData,
    StDone
  } flash_state_e;

  // Bytes arrive in flash order; the first byte belongs in the low lane of the SRAM word.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/flash_spi_shifter.sv
// SPI mode-0 bit engine: two clk cycles per bit (low phase, then high phase).
// A segment of up to 32 bits is loaded left-aligned; MOSI is shifted MSB first and MISO is
// sampled on the edge that raises SCK. done_o marks the high phase of the final bit so the
// caller can chain the next segment with no gap.
module flash_spi_shifter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] tx_data_i,
  input  logic [5:0]  num_bits_i,
  input  logic        miso_i,
  output logic        sck_o,
  output logic        mosi_o,
  output logic [31:0] rx_data_o,
  output logic        done_o
);

  logic        active_q, active_d;
  logic        sck_q, sck_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;

  // Next-state: abort beats start, start beats the running phase toggle.
  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    if (abort_i) begin
      active_d = 1'b0;
      sck_d    = 1'b0;
      tx_d     = '0;
    end else if (start_i) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      cnt_d    = 5'(num_bits_i - 6'd1);
      tx_d     = tx_data_i;
    end else if (active_q) begin
      if (!sck_q) begin
        sck_d = 1'b1;
        rx_d  = {rx_q[30:0], miso_i};
      end else begin
        sck_d = 1'b0;
        tx_d  = {tx_q[30:0], 1'b0};
        if (cnt_q == 5'd0) begin
          active_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      cnt_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  assign sck_o     = sck_q;
  assign mosi_o    = tx_q[31];
  assign rx_data_o = rx_q;
  assign done_o    = active_q && sck_q && (cnt_q == 5'd0);

endmodule

// File: rtl/flash_page_loader.sv
// Loads one 2048-byte SPI flash page into a word-wide page-cache SRAM using the 0x03 read
// command. The FSM chains command, address and data segments on the bit shifter back to
// back, so a load runs (8 + 24 + 32 * PAGE_WORDS) * 2 cycles from the first SCK low phase.
module flash_page_loader
  import flash_pkg::*;
#(
  parameter int unsigned PAGE_WORDS         = PAGE_WORDS_DEFAULT,
  parameter int unsigned FLASH_ADDRESS_BITS = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      loadRequest,
  input  logic [PAGE_ADDR_BITS-1:0] pageAddress,
  output logic                      busy,
  output logic                      pageValid,
  output logic [PAGE_ADDR_BITS-1:0] loadedPage,
  output logic                      flash_csb,
  output logic                      flash_clk,
  output logic                      flash_io0,
  input  logic                      flash_io1,
  output logic                      sramWriteEnable,
  output logic [WORD_IDX_BITS-1:0]  sramAddress,
  output logic [31:0]               sramData
);

  localparam logic [WORD_IDX_BITS-1:0] LastWord = WORD_IDX_BITS'(PAGE_WORDS - 1);

  flash_state_e              state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      page_valid_q, page_valid_d;
  logic [PAGE_ADDR_BITS-1:0] latched_page_q, latched_page_d;
  logic [PAGE_ADDR_BITS-1:0] loaded_page_q, loaded_page_d;
  logic                      csb_q, csb_d;
  logic                      sram_we_q, sram_we_d;
  logic [WORD_IDX_BITS-1:0]  sram_addr_q, sram_addr_d;
  logic [31:0]               sram_data_q, sram_data_d;
  logic [WORD_IDX_BITS-1:0]  word_idx_q, word_idx_d;

  logic        shift_start;
  logic        shift_abort;
  logic        shift_done;
  logic [31:0] shift_tx;
  logic [5:0]  shift_bits;
  logic [31:0] shift_rx;
  logic [31:0] addr_tx;

  // Flash byte address, left-aligned for MSB-first shifting.
  assign addr_tx = 32'({latched_page_q, {PAGE_OFFSET_BITS{1'b0}}}) << (32 - FLASH_ADDRESS_BITS);

  flash_spi_shifter u_shifter (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (shift_start),
    .abort_i    (shift_abort),
    .tx_data_i  (shift_tx),
    .num_bits_i (shift_bits),
    .miso_i     (flash_io1),
    .sck_o      (flash_clk),
    .mosi_o     (flash_io0),
    .rx_data_o  (shift_rx),
    .done_o     (shift_done)
  );

  // Load sequencing: accept in idle, chain segments on shifter done, abort when disabled.
  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    page_valid_d   = page_valid_q;
    latched_page_d = latched_page_q;
    loaded_page_d  = loaded_page_q;
    csb_d          = csb_q;
    sram_we_d      = 1'b0;
    sram_addr_d    = sram_addr_q;
    sram_data_d    = sram_data_q;
    word_idx_d     = word_idx_q;
    shift_start    = 1'b0;
    shift_abort    = 1'b0;
    shift_tx       = '0;
    shift_bits     = '0;

    if (state_q == StIdle) begin
      if (loadRequest && enable) begin
        latched_page_d = pageAddress;
        busy_d         = 1'b1;
        page_valid_d   = 1'b0;
        csb_d          = 1'b0;
        shift_start    = 1'b1;
        shift_tx       = {FLASH_READ_CMD, 24'h0};
        shift_bits     = 6'd8;
        state_d        = StCommand;
      end
    end else if (!enable) begin
      // Disable wins over everything, including a word completing this cycle.
      shift_abort  = 1'b1;
      busy_d       = 1'b0;
      page_valid_d = 1'b0;
      csb_d        = 1'b1;
      state_d      = StIdle;
    end else begin
      case (state_q)
        StCommand: begin
          if (shift_done) begin
            shift_start = 1'b1;
            shift_tx    = addr_tx;
            shift_bits  = 6'(FLASH_ADDRESS_BITS);
            state_d     = StAddress;
          end
        end
        StAddress: begin
          if (shift_done) begin
            shift_start = 1'b1;
            shift_bits  = 6'd32;
            word_idx_d  = '0;
            state_d     = StData;
          end
        end
        StData: begin
          if (shift_done) begin
            sram_we_d   = 1'b1;
            sram_addr_d = word_idx_q;
            sram_data_d = byte_swap32(shift_rx);
            if (word_idx_q == LastWord) begin
              csb_d         = 1'b1;
              loaded_page_d = latched_page_q;
              page_valid_d  = 1'b1;
              state_d       = StDone;
            end else begin
              shift_start = 1'b1;
              shift_bits  = 6'd32;
              word_idx_d  = word_idx_q + 1'b1;
            end
          end
        end
        StDone: begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      busy_q         <= 1'b0;
      page_valid_q   <= 1'b0;
      latched_page_q <= '0;
      loaded_page_q  <= '0;
      csb_q          <= 1'b1;
      sram_we_q      <= 1'b0;
      sram_addr_q    <= '0;
      sram_data_q    <= '0;
      word_idx_q     <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      page_valid_q   <= page_valid_d;
      latched_page_q <= latched_page_d;
      loaded_page_q  <= loaded_page_d;
      csb_q          <= csb_d;
      sram_we_q      <= sram_we_d;
      sram_addr_q    <= sram_addr_d;
      sram_data_q    <= sram_data_d;
      word_idx_q     <= word_idx_d;
    end
  end

  assign busy            = busy_q;
  assign pageValid       = page_valid_q;
  assign loadedPage      = loaded_page_q;
  assign flash_csb       = csb_q;
  assign sramWriteEnable = sram_we_q;
  assign sramAddress     = sram_addr_q;
  assign sramData        = sram_data_q;

endmodule

// File: tb/tb_flash_page_loader.sv
// Bench for flash_page_loader: behavioural SPI flash model with hashed contents, an SRAM
// write scoreboard, and SCK/CSB protocol monitoring.
module tb_flash_page_loader;

  localparam int PW          = 512;
  localparam int LOAD_CYCLES = (8 + 24 + 32 * PW) * 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        loadRequest;
  logic [12:0] pageAddress;
  logic        busy;
  logic        pageValid;
  logic [12:0] loadedPage;
  logic        flash_csb;
  logic        flash_clk;
  logic        flash_io0;
  logic        flash_io1 = 1'b0;
  logic        sramWriteEnable;
  logic [8:0]  sramAddress;
  logic [31:0] sramData;

  always #5 clk = ~clk;

  flash_page_loader #(
    .PAGE_WORDS         (PW),
    .FLASH_ADDRESS_BITS (24)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .loadRequest     (loadRequest),
    .pageAddress     (pageAddress),
    .busy            (busy),
    .pageValid       (pageValid),
    .loadedPage      (loadedPage),
    .flash_csb       (flash_csb),
    .flash_clk       (flash_clk),
    .flash_io0       (flash_io0),
    .flash_io1       (flash_io1),
    .sramWriteEnable (sramWriteEnable),
    .sramAddress     (sramAddress),
    .sramData        (sramData)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Flash contents: fixed first word of page 0, hashed bytes elsewhere.
  logic [31:0] key;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [31:0] h;
    logic [7:0]  r;
    h = ({8'h0, a} * 32'h9E37_79B1) ^ key;
    r = h[23:16];
    case (a)
      24'd0:        r = 8'h13;
      24'd1:        r = 8'h05;
      24'd2, 24'd3: r = 8'h00;
      default:      ;
    endcase
    return r;
  endfunction

  // Expected SRAM word: four consecutive flash bytes, first byte in the low lane.
  function automatic logic [31:0] exp_word(input logic [12:0] page, input int idx);
    logic [23:0] b;
    b = {page, 11'b0} + 24'(idx * 4);
    return {flash_byte(b + 24'd3), flash_byte(b + 24'd2), flash_byte(b + 24'd1), flash_byte(b)};
  endfunction

  int          cyc = 0;
  logic        prev_sck = 1'b0;
  logic        prev_csb = 1'b1;
  int          bit_cnt = 0;
  logic [31:0] mosi_word = '0;
  int          wr_count = 0;
  int          wr_errs = 0;
  int          sck_viol = 0;
  int          t_csb_low = 0;
  logic [31:0] word0 = '0;
  logic [12:0] cur_page = '0;

  always @(posedge clk) cyc++;

  // Flash device model, protocol monitor and SRAM scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    int          k;
    logic [7:0]  bv;
    if (flash_csb && flash_clk) sck_viol++;
    if (!flash_csb) begin
      if (prev_csb) begin
        if (flash_clk) sck_viol++;
        bit_cnt   = 0;
        mosi_word = '0;
        t_csb_low = cyc;
      end else if (flash_clk == prev_sck) begin
        sck_viol++;
      end
      if (flash_clk && !prev_sck) begin
        if (bit_cnt < 32) mosi_word = {mosi_word[30:0], flash_io0};
        bit_cnt++;
      end
      if (!flash_clk && prev_sck && bit_cnt >= 32) begin
        k  = bit_cnt - 32;
        bv = flash_byte(mosi_word[23:0] + 24'(k / 8));
        flash_io1 = bv[7 - (k % 8)];
      end
    end else begin
      flash_io1 = 1'b0;
    end
    if (sramWriteEnable) begin
      if (wr_count == 0) word0 = sramData;
      if (sramAddress !== 9'(wr_count) || sramData !== exp_word(cur_page, wr_count)) wr_errs++;
      wr_count++;
    end
    prev_sck = flash_clk;
    prev_csb = flash_csb;
  end

  // Called just after a posedge; pulses loadRequest for exactly one cycle.
  task automatic request(input logic [12:0] p);
    pageAddress = p;
    loadRequest = 1'b1;
    @(posedge clk);
    #1;
    loadRequest = 1'b0;
    pageAddress = 13'($urandom);
  endtask

  task automatic wait_writes(input int n, input string tag);
    int to;
    to = 1;
    for (int i = 0; i < 40000; i++) begin
      @(posedge clk);
      #1;
      if (wr_count >= n) begin
        to = 0;
        break;
      end
    end
    check(tag, to, 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_pv"}, pageValid, 0);
    check({pfx, "_loaded"}, loadedPage, 0);
    check({pfx, "_csb"}, flash_csb, 1);
    check({pfx, "_sck"}, flash_clk, 0);
    check({pfx, "_io0"}, flash_io0, 0);
    check({pfx, "_we"}, sramWriteEnable, 0);
    check({pfx, "_addr"}, sramAddress, 0);
    check({pfx, "_data"}, sramData, 0);
  endtask

  initial begin
    int          busy_low;
    int          to;
    int          snap;
    logic [31:0] exp3;

    key         = $urandom;
    rst_n       = 1'b0;
    enable      = 1'b0;
    loadRequest = 1'b0;
    pageAddress = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Request while disabled is ignored.
    request(13'd5);
    @(posedge clk);
    #1;
    check("dis_busy", busy, 0);
    check("dis_csb", flash_csb, 1);

    // Full load of page 0 with two stray requests during the load.
    enable   = 1'b1;
    cur_page = 13'd0;
    wr_count = 0;
    wr_errs  = 0;
    busy_low = 0;
    to       = 1;
    request(13'd0);
    for (int i = 1; i <= 40000; i++) begin
      @(posedge clk);
      #1;
      if (i == 100 || i == 5000) begin
        loadRequest = 1'b1;
        pageAddress = 13'($urandom_range(1, 8191));
      end else begin
        loadRequest = 1'b0;
      end
      if (pageValid) begin
        to = 0;
        break;
      end
      if (!busy) busy_low++;
    end
    loadRequest = 1'b0;
    @(negedge clk);
    #1;
    check("a_timeout", to, 0);
    check("a_load_cycles", cyc - t_csb_low, LOAD_CYCLES);
    check("a_done_busy", busy, 1);
    check("a_done_csb", flash_csb, 1);
    check("a_done_sck", flash_clk, 0);
    check("a_loaded", loadedPage, 0);
    check("a_writes", wr_count, PW);
    check("a_word0", word0, 32'h0000_0513);
    check("a_wr_errs", wr_errs, 0);
    check("a_busy_gap", busy_low, 0);
    check("a_mosi", mosi_word, 32'h0300_0000);
    @(posedge clk);
    #1;
    check("a_idle_busy", busy, 0);
    check("a_idle_pv", pageValid, 1);
    repeat (200) @(posedge clk);
    #1;
    check("a_no_reload", wr_count, PW);

    // Page 3, disabled while word 200 is in flight.
    cur_page = 13'd3;
    wr_count = 0;
    wr_errs  = 0;
    request(13'd3);
    check("b_accept_pv", pageValid, 0);
    wait_writes(200, "b_timeout");
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("b_abort_csb", flash_csb, 1);
    check("b_abort_busy", busy, 0);
    check("b_abort_pv", pageValid, 0);
    check("b_abort_sck", flash_clk, 0);
    check("b_mosi", mosi_word, 32'h0300_1800);
    exp3 = {flash_byte(24'h1803), flash_byte(24'h1802), flash_byte(24'h1801), flash_byte(24'h1800)};
    check("b_word0", word0, exp3);
    check("b_wr_errs", wr_errs, 0);
    repeat (300) @(posedge clk);
    #1;
    check("b_no_late_wr", wr_count, 200);
    check("b_loaded", loadedPage, 0);

    // Reset pulse in the middle of the data phase.
    enable   = 1'b1;
    cur_page = 13'($urandom_range(1, 8191));
    wr_count = 0;
    wr_errs  = 0;
    request(cur_page);
    wait_writes(10, "c_timeout");
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("c_rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap = wr_count;
    repeat (300) @(posedge clk);
    #1;
    check("c_no_wr_after_rst", wr_count, snap);
    check("c_idle_busy", busy, 0);
    check("c_wr_errs", wr_errs, 0);

    // A fresh request after reset loads again.
    cur_page = 13'($urandom_range(1, 8191));
    wr_count = 0;
    wr_errs  = 0;
    request(cur_page);
    wait_writes(4, "d_timeout");
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("d_mosi", mosi_word, {8'h03, cur_page, 11'b0});
    check("d_wr_errs", wr_errs, 0);
    check("d_abort_busy", busy, 0);
    check("sck_protocol", sck_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
